// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the decode/execute boundary.
// It also holds the small helpers the issue stage uses to decide which operand registers an instruction reads.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluop_t;

    typedef enum logic {
        ASEL_RS = 1'b0,
        ASEL_RT = 1'b1
    } asel_t;

    typedef enum logic [1:0] {
        BSEL_RT    = 2'd0,
        BSEL_IMM   = 2'd1,
        BSEL_SHAMT = 2'd2
    } bsel_t;

    // Marker driven onto operand B for the unused select encoding.
    localparam word_t BSEL_BAD_WORD = 32'h0BAD_C0DE;

    function automatic logic reads_rs(input asel_t asel);
        return (asel == ASEL_RS);
    endfunction

    function automatic logic reads_rt(input asel_t asel, input bsel_t bsel);
        return (asel == ASEL_RT) || (bsel == BSEL_RT);
    endfunction

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Forwarding select for one source operand.
// The EX/MEM result takes priority over MEM/WB. A load still in EX/MEM has no data yet, and register $0 never forwards.
module fwd_mux
    import cpu_types_pkg::*;
(
    input  regbits_t i_reg,
    input  word_t    i_reg_data,
    input  logic     i_exmem_wen,
    input  logic     i_exmem_memread,
    input  regbits_t i_exmem_wsel,
    input  word_t    i_exmem_wdat,
    input  logic     i_memwb_wen,
    input  regbits_t i_memwb_wsel,
    input  word_t    i_memwb_wdat,
    output word_t    o_data
);

    // Pick the youngest producer of i_reg, falling back to register-file data.
    always_comb begin
        o_data = i_reg_data;
        if (i_exmem_wen && !i_exmem_memread && (i_exmem_wsel == i_reg) && (i_reg != 5'd0)) begin
            o_data = i_exmem_wdat;
        end else if (i_memwb_wen && (i_memwb_wsel == i_reg) && (i_reg != 5'd0)) begin
            o_data = i_memwb_wdat;
        end else begin
            o_data = i_reg_data;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// One-entry decode-to-execute pipeline register.
// It detects load-use hazards, inserts a bubble for them, and forwards EX/MEM and MEM/WB results onto the ALU operands.
module alu_issue
    import cpu_types_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  aluop_t                 in_aluop,
    input  regbits_t               in_rs,
    input  regbits_t               in_rt,
    input  word_t                  in_rdat1,
    input  word_t                  in_rdat2,
    input  word_t                  in_imm,
    input  logic [4:0]             in_shamt,
    input  asel_t                  in_asel,
    input  bsel_t                  in_bsel,
    input  regbits_t               in_wsel,
    input  logic                   in_wen,
    input  logic                   in_memread,
    input  logic                   exmem_wen,
    input  logic                   exmem_memread,
    input  regbits_t               exmem_wsel,
    input  word_t                  exmem_wdat,
    input  logic                   memwb_wen,
    input  regbits_t               memwb_wsel,
    input  word_t                  memwb_wdat,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   out_valid,
    output aluop_t                 out_aluop,
    output word_t                  out_a,
    output word_t                  out_b,
    output regbits_t               out_wsel,
    output logic                   out_wen,
    output logic                   out_memread,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic                   r_valid;
    aluop_t                 r_aluop;
    regbits_t               r_rs;
    regbits_t               r_rt;
    word_t                  r_rdat1;
    word_t                  r_rdat2;
    word_t                  r_imm;
    logic [4:0]             r_shamt;
    asel_t                  r_asel;
    bsel_t                  r_bsel;
    regbits_t               r_wsel;
    logic                   r_wen;
    logic                   r_memread;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic  w_advance;
    logic  w_src_match;
    logic  w_hazard;
    logic  w_capture;
    word_t w_fwd_rs;
    word_t w_fwd_rt;
    word_t w_out_b;

    // The held load's result is not ready until MEM, so a reader of its destination has to wait one cycle.
    assign w_src_match = (reads_rs(in_asel) && (r_wsel == in_rs))
                      || (reads_rt(in_asel, in_bsel) && (r_wsel == in_rt));
    assign w_hazard    = in_valid && r_valid && r_memread && r_wen
                      && (r_wsel != 5'd0) && w_src_match;
    assign w_advance   = ex_ready || !r_valid;
    assign in_ready    = flush || (w_advance && !w_hazard);
    assign w_capture   = in_valid && in_ready;

    // Pipeline register: reset, flush, capture, bubble, drain or hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid     <= 1'b0;
            r_aluop     <= ALU_SLL;
            r_rs        <= 5'd0;
            r_rt        <= 5'd0;
            r_rdat1     <= 32'd0;
            r_rdat2     <= 32'd0;
            r_imm       <= 32'd0;
            r_shamt     <= 5'd0;
            r_asel      <= ASEL_RS;
            r_bsel      <= BSEL_RT;
            r_wsel      <= 5'd0;
            r_wen       <= 1'b0;
            r_memread   <= 1'b0;
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_aluop   <= in_aluop;
            r_rs      <= in_rs;
            r_rt      <= in_rt;
            r_rdat1   <= in_rdat1;
            r_rdat2   <= in_rdat2;
            r_imm     <= in_imm;
            r_shamt   <= in_shamt;
            r_asel    <= in_asel;
            r_bsel    <= in_bsel;
            r_wsel    <= in_wsel;
            r_wen     <= in_wen;
            r_memread <= in_memread;
        end else if (w_advance && w_hazard) begin
            r_valid <= 1'b0;
            if (r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end else if (w_advance) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    fwd_mux u_fwd_rs (
        .i_reg           (r_rs),
        .i_reg_data      (r_rdat1),
        .i_exmem_wen     (exmem_wen),
        .i_exmem_memread (exmem_memread),
        .i_exmem_wsel    (exmem_wsel),
        .i_exmem_wdat    (exmem_wdat),
        .i_memwb_wen     (memwb_wen),
        .i_memwb_wsel    (memwb_wsel),
        .i_memwb_wdat    (memwb_wdat),
        .o_data          (w_fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .i_reg           (r_rt),
        .i_reg_data      (r_rdat2),
        .i_exmem_wen     (exmem_wen),
        .i_exmem_memread (exmem_memread),
        .i_exmem_wsel    (exmem_wsel),
        .i_exmem_wdat    (exmem_wdat),
        .i_memwb_wen     (memwb_wen),
        .i_memwb_wsel    (memwb_wsel),
        .i_memwb_wdat    (memwb_wdat),
        .o_data          (w_fwd_rt)
    );

    // Operand B source select for the held instruction.
    always_comb begin
        w_out_b = BSEL_BAD_WORD;
        case (r_bsel)
            BSEL_RT:    w_out_b = w_fwd_rt;
            BSEL_IMM:   w_out_b = r_imm;
            BSEL_SHAMT: w_out_b = {27'd0, r_shamt};
            default:    w_out_b = BSEL_BAD_WORD;
        endcase
    end

    assign out_a       = (r_asel == ASEL_RT) ? w_fwd_rt : w_fwd_rs;
    assign out_b       = w_out_b;
    assign out_valid   = r_valid;
    assign out_aluop   = r_aluop;
    assign out_wsel    = r_wsel;
    assign out_wen     = r_wen;
    assign out_memread = r_memread;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a directed vector table, a stall-counter saturation sequence, and a randomized run against a reference model.
module tb_alu_issue;
    import cpu_types_pkg::*;

    localparam int W  = 16;
    localparam int WS = 2;

    typedef struct {
        aluop_t     aluop;
        regbits_t   rs;
        regbits_t   rt;
        word_t      rdat1;
        word_t      rdat2;
        word_t      imm;
        logic [4:0] shamt;
        asel_t      asel;
        bsel_t      bsel;
        regbits_t   wsel;
        logic       wen;
        logic       memread;
    } inst_t;

    typedef struct {
        logic     valid;
        inst_t    ins;
        logic     exm_wen;
        logic     exm_mr;
        regbits_t exm_wsel;
        word_t    exm_wdat;
        logic     mwb_wen;
        regbits_t mwb_wsel;
        word_t    mwb_wdat;
        logic     exr;
        logic     fl;
        logic     e_ready;
        logic     e_valid;
        word_t    e_a;
        word_t    e_b;
        regbits_t e_wsel;
        int       e_stall;
    } vec_t;

    logic     CLK = 1'b0;
    logic     RST;
    logic     in_valid;
    inst_t    cur;
    logic     exmem_wen, exmem_memread, memwb_wen, flush, ex_ready;
    regbits_t exmem_wsel, memwb_wsel;
    word_t    exmem_wdat, memwb_wdat;

    logic          in_ready, out_valid, out_wen, out_memread;
    aluop_t        out_aluop;
    word_t         out_a, out_b;
    regbits_t      out_wsel;
    logic [W-1:0]  stall_count;
    logic          s_in_ready, s_out_valid, s_out_wen, s_out_memread;
    aluop_t        s_out_aluop;
    word_t         s_out_a, s_out_b;
    regbits_t      s_out_wsel;
    logic [WS-1:0] s_stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic  m_valid;
    inst_t m_ins;
    int    m_cnt;

    vec_t  tbl[25];
    inst_t nop_i, sub_i, xor_i;

    always #5 CLK = ~CLK;

    alu_issue #(.STALL_CNT_W(W)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(cur.aluop), .in_rs(cur.rs), .in_rt(cur.rt),
        .in_rdat1(cur.rdat1), .in_rdat2(cur.rdat2), .in_imm(cur.imm),
        .in_shamt(cur.shamt), .in_asel(cur.asel), .in_bsel(cur.bsel),
        .in_wsel(cur.wsel), .in_wen(cur.wen), .in_memread(cur.memread),
        .exmem_wen(exmem_wen), .exmem_memread(exmem_memread),
        .exmem_wsel(exmem_wsel), .exmem_wdat(exmem_wdat),
        .memwb_wen(memwb_wen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid),
        .out_aluop(out_aluop), .out_a(out_a), .out_b(out_b),
        .out_wsel(out_wsel), .out_wen(out_wen), .out_memread(out_memread),
        .stall_count(stall_count)
    );

    // Narrow-counter copy on the same stimulus, so saturation is reachable in a few cycles.
    alu_issue #(.STALL_CNT_W(WS)) dut_small (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_aluop(cur.aluop), .in_rs(cur.rs), .in_rt(cur.rt),
        .in_rdat1(cur.rdat1), .in_rdat2(cur.rdat2), .in_imm(cur.imm),
        .in_shamt(cur.shamt), .in_asel(cur.asel), .in_bsel(cur.bsel),
        .in_wsel(cur.wsel), .in_wen(cur.wen), .in_memread(cur.memread),
        .exmem_wen(exmem_wen), .exmem_memread(exmem_memread),
        .exmem_wsel(exmem_wsel), .exmem_wdat(exmem_wdat),
        .memwb_wen(memwb_wen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .flush(flush), .ex_ready(ex_ready), .out_valid(s_out_valid),
        .out_aluop(s_out_aluop), .out_a(s_out_a), .out_b(s_out_b),
        .out_wsel(s_out_wsel), .out_wen(s_out_wen), .out_memread(s_out_memread),
        .stall_count(s_stall_count)
    );

    function automatic inst_t mk(aluop_t op, regbits_t rs, word_t d1, regbits_t rt, word_t d2,
                                 asel_t as, bsel_t bs, word_t imm, logic [4:0] sh,
                                 regbits_t ws, logic wen, logic mr);
        inst_t i;
        i.aluop = op; i.rs = rs; i.rdat1 = d1; i.rt = rt; i.rdat2 = d2;
        i.asel = as; i.bsel = bs; i.imm = imm; i.shamt = sh;
        i.wsel = ws; i.wen = wen; i.memread = mr;
        return i;
    endfunction

    function automatic vec_t row(logic v, inst_t ins, logic exr, logic fl, logic er, logic ev,
                                 word_t ea, word_t eb, regbits_t ews, int est);
        vec_t r;
        r.valid = v; r.ins = ins; r.exr = exr; r.fl = fl;
        r.exm_wen = 1'b0; r.exm_mr = 1'b0; r.exm_wsel = 5'd0; r.exm_wdat = 32'd0;
        r.mwb_wen = 1'b0; r.mwb_wsel = 5'd0; r.mwb_wdat = 32'd0;
        r.e_ready = er; r.e_valid = ev; r.e_a = ea; r.e_b = eb; r.e_wsel = ews; r.e_stall = est;
        return r;
    endfunction

    // Reference model: written from the stage's rules, not from the RTL structure.
    function automatic logic reads_reg(inst_t i, regbits_t r);
        return (i.asel == ASEL_RS && i.rs == r)
            || ((i.asel == ASEL_RT || i.bsel == BSEL_RT) && i.rt == r);
    endfunction

    function automatic logic m_hazard();
        return in_valid && m_valid && m_ins.memread && m_ins.wen
            && (m_ins.wsel != 5'd0) && reads_reg(cur, m_ins.wsel);
    endfunction

    function automatic logic m_ready();
        return flush || ((ex_ready || !m_valid) && !m_hazard());
    endfunction

    function automatic word_t m_fwd(regbits_t r, word_t d);
        if (r != 5'd0 && exmem_wen && exmem_wsel == r && !exmem_memread) return exmem_wdat;
        if (r != 5'd0 && memwb_wen && memwb_wsel == r) return memwb_wdat;
        return d;
    endfunction

    function automatic word_t m_a();
        return (m_ins.asel == ASEL_RS) ? m_fwd(m_ins.rs, m_ins.rdat1) : m_fwd(m_ins.rt, m_ins.rdat2);
    endfunction

    function automatic word_t m_b();
        case (m_ins.bsel)
            BSEL_RT:    return m_fwd(m_ins.rt, m_ins.rdat2);
            BSEL_IMM:   return m_ins.imm;
            BSEL_SHAMT: return {27'd0, m_ins.shamt};
            default:    return 32'h0BAD_C0DE;
        endcase
    endfunction

    task automatic model_edge();
        logic adv, hz, rdy;
        adv = ex_ready || !m_valid;
        hz  = m_hazard();
        rdy = m_ready();
        if (RST) begin
            m_valid = 1'b0; m_ins = nop_i; m_ins.aluop = ALU_SLL; m_cnt = 0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && rdy) begin
            m_valid = 1'b1; m_ins = cur;
        end else if (adv && hz) begin
            m_valid = 1'b0; m_cnt = m_cnt + 1;
        end else if (adv) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(vec_t v);
        in_valid = v.valid; cur = v.ins; ex_ready = v.exr; flush = v.fl;
        exmem_wen = v.exm_wen; exmem_memread = v.exm_mr; exmem_wsel = v.exm_wsel; exmem_wdat = v.exm_wdat;
        memwb_wen = v.mwb_wen; memwb_wsel = v.mwb_wsel; memwb_wdat = v.mwb_wdat;
    endtask

    task automatic compare_model(int cyc);
        int e_main, e_small;
        e_main  = (m_cnt > 65535) ? 65535 : m_cnt;
        e_small = (m_cnt > 3) ? 3 : m_cnt;
        chk($sformatf("rnd%0d_ready", cyc), {31'd0, in_ready}, {31'd0, m_ready()});
        chk($sformatf("rnd%0d_valid", cyc), {31'd0, out_valid}, {31'd0, m_valid});
        chk($sformatf("rnd%0d_a", cyc), out_a, m_a());
        chk($sformatf("rnd%0d_b", cyc), out_b, m_b());
        chk($sformatf("rnd%0d_fields", cyc), {20'd0, out_aluop, out_wsel, out_wen, out_memread},
            {20'd0, m_ins.aluop, m_ins.wsel, m_ins.wen, m_ins.memread});
        chk($sformatf("rnd%0d_stall", cyc), {16'd0, stall_count}, e_main);
        chk($sformatf("rnd%0d_stall_small", cyc), {30'd0, s_stall_count}, e_small);
    endtask

    // EX/MEM must never present a load that the held valid instruction reads.
    always @(negedge CLK) begin
        if (RST === 1'b0 && m_valid === 1'b1 && exmem_wen && exmem_memread && exmem_wsel != 5'd0
            && (exmem_wsel == m_ins.rs || exmem_wsel == m_ins.rt)) begin
            n_fail++;
            $display("FAIL protocol: exmem load to r%0d while held instruction valid", exmem_wsel);
        end
    end

    initial begin
        nop_i = mk(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, ASEL_RS, BSEL_RT, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sub_i = mk(ALU_SUB, 5'd4, 32'h44, 5'd2, 32'h9, ASEL_RS, BSEL_RT, 32'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        xor_i = mk(ALU_XOR, 5'd7, 32'h70, 5'd8, 32'h80, ASEL_RS, BSEL_RT, 32'd0, 5'd0, 5'd10, 1'b1, 1'b0);

        tbl[0]  = row(1'b1, mk(ALU_ADD, 5'd1, 32'd10, 5'd2, 32'd20, ASEL_RS, BSEL_RT, 32'd0, 5'd0, 5'd5, 1'b1, 1'b0),
                      1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 0);
        tbl[1]  = row(1'b0, nop_i, 1'b1, 1'b0, 1'b1, 1'b1, 32'd10, 32'd20, 5'd5, 0);
        tbl[2]  = row(1'b1, mk(ALU_ADD, 5'd3, 32'h33, 5'd2, 32'h22, ASEL_RS, BSEL_RT, 32'd0, 5'd0, 5'd6, 1'b1, 1'b0),
                      1'b1, 1'b0, 1'b1, 1'b0, 32'd10, 32'd20, 5'd5, 0);
        tbl[3]  = row(1'b0, nop_i, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h22, 5'd6, 0);
        tbl[3].exm_wen = 1'b1; tbl[3].exm_wsel = 5'd3; tbl[3].exm_wdat = 32'h55;
        tbl[3].mwb_wen = 1'b1; tbl[3].mwb_wsel = 5'd3; tbl[3].mwb_wdat = 32'h66;
        tbl[4]  = row(1'b0, nop_i, 1'b0, 1'b0, 1'b0, 1'b1, 32'h66, 32'h22, 5'd6, 0);
        tbl[4].mwb_wen = 1'b1; tbl[4].mwb_wsel = 5'd3; tbl[4].mwb_wdat = 32'h66;
        tbl[5]  = row(1'b1, mk(ALU_ADD, 5'd0, 32'h77, 5'd0, 32'h88, ASEL_RS, BSEL_RT, 32'd0, 5'd0, 5'd7, 1'b1, 1'b0),
                      1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 32'h22, 5'd6, 0);
        tbl[5].exm_wen = 1'b1; tbl[5].exm_wsel = 5'd0; tbl[5].exm_wdat = 32'h55;
        tbl[5].mwb_wen = 1'b1; tbl[5].mwb_wsel = 5'd0; tbl[5].mwb_wdat = 32'h66;
        tbl[6]  = row(1'b0, nop_i, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 32'h88, 5'd7, 0);
        tbl[6].exm_wen = 1'b1; tbl[6].exm_wsel = 5'd0; tbl[6].exm_wdat = 32'h55;
        tbl[6].mwb_wen = 1'b1; tbl[6].mwb_wsel = 5'd0; tbl[6].mwb_wdat = 32'h66;
        tbl[7]  = row(1'b1, mk(ALU_ADD, 5'd1, 32'h100, 5'd0, 32'd0, ASEL_RS, BSEL_IMM, 32'd4, 5'd0, 5'd4, 1'b1, 1'b1),
                      1'b1, 1'b0, 1'b1, 1'b1, 32'h77, 32'h88, 5'd7, 0);
        tbl[8]  = row(1'b1, sub_i, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'd4, 5'd4, 0);
        tbl[9]  = row(1'b1, sub_i, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'd4, 5'd4, 1);
        tbl[9].exm_wen = 1'b1; tbl[9].exm_mr = 1'b1; tbl[9].exm_wsel = 5'd4; tbl[9].exm_wdat = 32'h1234;
        tbl[10] = row(1'b0, nop_i, 1'b1, 1'b0, 1'b1, 1'b1, 32'hABC, 32'd9, 5'd8, 1);
        tbl[10].mwb_wen = 1'b1; tbl[10].mwb_wsel = 5'd4; tbl[10].mwb_wdat = 32'hABC;
        tbl[11] = row(1'b1, mk(ALU_ADD, 5'd5, 32'd5, 5'd6, 32'd6, ASEL_RS, BSEL_RT, 32'd0, 5'd0, 5'd9, 1'b1, 1'b0),
                      1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'd9, 5'd8, 1);
        tbl[12] = row(1'b1, xor_i, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd6, 5'd9, 1);
        tbl[13] = tbl[12];
        tbl[14] = tbl[12];
        tbl[15] = row(1'b1, xor_i, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 32'd6, 5'd9, 1);
        tbl[16] = row(1'b0, nop_i, 1'b0, 1'b0, 1'b0, 1'b1, 32'h70, 32'h80, 5'd10, 1);
        tbl[17] = row(1'b1, mk(ALU_ADD, 5'd1, 32'h10, 5'd0, 32'd0, ASEL_RS, BSEL_IMM, 32'd8, 5'd0, 5'd11, 1'b1, 1'b1),
                      1'b1, 1'b0, 1'b1, 1'b1, 32'h70, 32'h80, 5'd10, 1);
        tbl[18] = row(1'b1, mk(ALU_ADD, 5'd11, 32'd1, 5'd11, 32'd1, ASEL_RS, BSEL_RT, 32'd0, 5'd0, 5'd12, 1'b1, 1'b0),
                      1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'd8, 5'd11, 1);
        tbl[19] = row(1'b0, nop_i, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'd8, 5'd11, 1);
        tbl[20] = row(1'b1, mk(ALU_SLL, 5'd0, 32'd0, 5'd9, 32'h99, ASEL_RT, BSEL_SHAMT, 32'd0, 5'd5, 5'd13, 1'b1, 1'b0),
                      1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'd8, 5'd11, 1);
        tbl[21] = row(1'b0, nop_i, 1'b1, 1'b0, 1'b1, 1'b1, 32'h99, 32'd5, 5'd13, 1);
        tbl[22] = row(1'b1, mk(ALU_OR, 5'd2, 32'd2, 5'd0, 32'd0, ASEL_RS, bsel_t'(2'd3), 32'd0, 5'd0, 5'd0, 1'b0, 1'b0),
                      1'b1, 1'b0, 1'b1, 1'b0, 32'h99, 32'd5, 5'd13, 1);
        tbl[23] = row(1'b0, nop_i, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 32'h0BAD_C0DE, 5'd0, 1);
        tbl[24] = row(1'b0, nop_i, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 32'h0BAD_C0DE, 5'd0, 1);
        tbl[24].exm_wen = 1'b1; tbl[24].exm_mr = 1'b1; tbl[24].exm_wsel = 5'd2; tbl[24].exm_wdat = 32'hDEAD;

        // Reset state.
        RST = 1'b1;
        apply(row(1'b0, nop_i, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0));
        tick();
        @(negedge CLK);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fields", {20'd0, out_aluop, out_wsel, out_wen, out_memread}, 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_b", out_b, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        chk("rst_stall_small", {30'd0, s_stall_count}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        RST = 1'b0;

        // Directed vector table: expectations are sampled before the row's clock edge.
        for (int k = 0; k < 25; k++) begin
            apply(tbl[k]);
            @(negedge CLK);
            chk($sformatf("row%0d_ready", k), {31'd0, in_ready}, {31'd0, tbl[k].e_ready});
            chk($sformatf("row%0d_valid", k), {31'd0, out_valid}, {31'd0, tbl[k].e_valid});
            chk($sformatf("row%0d_a", k), out_a, tbl[k].e_a);
            chk($sformatf("row%0d_b", k), out_b, tbl[k].e_b);
            chk($sformatf("row%0d_wsel", k), {27'd0, out_wsel}, {27'd0, tbl[k].e_wsel});
            chk($sformatf("row%0d_stall", k), {16'd0, stall_count}, tbl[k].e_stall);
            tick();
        end

        // Four more load-use pairs push the 2-bit counter past its maximum.
        for (int k = 0; k < 4; k++) begin
            apply(row(1'b1, mk(ALU_ADD, 5'd1, 32'h40, 5'd0, 32'd0, ASEL_RS, BSEL_IMM, 32'd0, 5'd0, 5'd4, 1'b1, 1'b1),
                      1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 5'd0, 0));
            @(negedge CLK);
            chk($sformatf("sat%0d_lw_ready", k), {31'd0, in_ready}, 32'd1);
            tick();
            apply(row(1'b1, sub_i, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 0));
            @(negedge CLK);
            chk($sformatf("sat%0d_hazard_ready", k), {31'd0, in_ready}, 32'd0);
            tick();
            @(negedge CLK);
            chk($sformatf("sat%0d_resume_ready", k), {31'd0, in_ready}, 32'd1);
            chk($sformatf("sat%0d_stall", k), {16'd0, stall_count}, 2 + k);
            chk($sformatf("sat%0d_stall_small", k), {30'd0, s_stall_count}, (2 + k > 3) ? 3 : 2 + k);
            tick();
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 2000; c++) begin
            in_valid      = ($urandom_range(3, 0) != 0);
            cur.aluop     = aluop_t'(4'($urandom_range(11, 0)));
            cur.rs        = 5'($urandom_range(7, 0));
            cur.rt        = 5'($urandom_range(7, 0));
            cur.rdat1     = $urandom;
            cur.rdat2     = $urandom;
            cur.imm       = $urandom;
            cur.shamt     = 5'($urandom_range(31, 0));
            cur.asel      = asel_t'(1'($urandom_range(1, 0)));
            cur.bsel      = bsel_t'(2'($urandom_range(3, 0)));
            cur.wsel      = 5'($urandom_range(7, 0));
            cur.wen       = ($urandom_range(3, 0) != 0);
            cur.memread   = ($urandom_range(2, 0) == 0);
            exmem_wen     = $urandom_range(1, 0) == 1;
            exmem_memread = $urandom_range(2, 0) == 0;
            exmem_wsel    = 5'($urandom_range(7, 0));
            exmem_wdat    = $urandom;
            memwb_wen     = $urandom_range(1, 0) == 1;
            memwb_wsel    = 5'($urandom_range(7, 0));
            memwb_wdat    = $urandom;
            flush         = ($urandom_range(15, 0) == 0);
            ex_ready      = ($urandom_range(3, 0) != 0);
            if (m_valid && exmem_wsel != 5'd0 && (exmem_wsel == m_ins.rs || exmem_wsel == m_ins.rt)) begin
                exmem_memread = 1'b0;
            end
            @(negedge CLK);
            compare_model(c);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
